// File: rtl/updown_shift_counter_pkg.sv
// Shared types for the up/down/shift counter: operation-select encodings.
package updown_shift_counter_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_UP   = 3'b001,
    MODE_DOWN = 3'b010,
    MODE_SHL  = 3'b011,
    MODE_SHR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_ROR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

endpackage

// File: rtl/updown_shift_counter_if.sv
// Control/data bundle for updown_shift_counter; master drives controls, slave owns Q and flags.
interface updown_shift_counter_if
  import updown_shift_counter_pkg::*;
#(
  parameter int unsigned SIZE = 16
);
  logic [SIZE-1:0] Initial;
  logic            Enable;
  mode_e           Mode;
  logic            Load;
  logic [SIZE-1:0] D;
  logic            SerialIn;
  logic            ClearOvf;
  logic [SIZE-1:0] Q;
  logic            SerialOut;
  logic            Terminal;
  logic            Overflow;

  modport master (
    output Initial, Enable, Mode, Load, D, SerialIn, ClearOvf,
    input  Q, SerialOut, Terminal, Overflow
  );

  modport slave (
    input  Initial, Enable, Mode, Load, D, SerialIn, ClearOvf,
    output Q, SerialOut, Terminal, Overflow
  );
endinterface

// File: rtl/updown_shift_counter_next.sv
// Pure combinational next-state for the register bank: next Q, bit shifted out, wrap event.
module updown_shift_next
  import updown_shift_counter_pkg::*;
#(
  parameter int unsigned    SIZE     = 16,
  parameter logic [SIZE-1:0] MAX     = '1,
  parameter bit             SATURATE = 1'b0
) (
  input  logic [SIZE-1:0] q,
  input  mode_e           mode,
  input  logic            serial_in,
  output logic [SIZE-1:0] q_next,
  output logic            shift_bit,
  output logic            shifting,
  output logic            wrap
);
  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  // Per-mode next value; counting honours MAX, shifts/rotates use the full width.
  always_comb begin
    q_next    = q;
    shift_bit = 1'b0;
    shifting  = 1'b0;
    wrap      = 1'b0;
    unique case (mode)
      MODE_UP: begin
        if (q < MAX) begin
          q_next = q + ONE;
        end else begin
          q_next = SATURATE ? MAX : '0;
          wrap   = 1'b1;
        end
      end
      MODE_DOWN: begin
        if (q == '0) begin
          q_next = SATURATE ? '0 : MAX;
          wrap   = 1'b1;
        end else if (q > MAX) begin
          // Out-of-range start snaps to the top without flagging overflow.
          q_next = MAX;
        end else begin
          q_next = q - ONE;
        end
      end
      MODE_SHL: begin
        q_next    = {q[SIZE-2:0], serial_in};
        shift_bit = q[SIZE-1];
        shifting  = 1'b1;
      end
      MODE_SHR: begin
        q_next    = {serial_in, q[SIZE-1:1]};
        shift_bit = q[0];
        shifting  = 1'b1;
      end
      MODE_ROL: begin
        q_next    = {q[SIZE-2:0], q[SIZE-1]};
        shift_bit = q[SIZE-1];
        shifting  = 1'b1;
      end
      MODE_ROR: begin
        q_next    = {q[0], q[SIZE-1:1]};
        shift_bit = q[0];
        shifting  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/updown_shift_counter.sv
// Selectable up/down counter, shifter and rotator with parallel load and sticky overflow.
module updown_shift_counter
  import updown_shift_counter_pkg::*;
#(
  parameter int unsigned     SIZE     = 16,
  parameter logic [SIZE-1:0] MAX      = '1,
  parameter bit              SATURATE = 1'b0
) (
  input logic                  Clock,
  input logic                  Reset,
  updown_shift_counter_if.slave bus
);
  logic [SIZE-1:0] q;
  logic            serial_out;
  logic            overflow;
  logic [SIZE-1:0] q_next;
  logic            shift_bit;
  logic            shifting;
  logic            wrap;
  logic            advance;

  updown_shift_next #(
    .SIZE    (SIZE),
    .MAX     (MAX),
    .SATURATE(SATURATE)
  ) u_next (
    .q        (q),
    .mode     (bus.Mode),
    .serial_in(bus.SerialIn),
    .q_next   (q_next),
    .shift_bit(shift_bit),
    .shifting (shifting),
    .wrap     (wrap)
  );

  assign advance = bus.Enable && !bus.Load;

  // Register bank with Reset > Load > Enable > hold; a set overflow beats a clear on the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      q          <= bus.Initial;
      serial_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (bus.Load) begin
        q <= bus.D;
      end else if (bus.Enable) begin
        q <= q_next;
        if (shifting) serial_out <= shift_bit;
      end
      if (advance && wrap) overflow <= 1'b1;
      else if (bus.ClearOvf) overflow <= 1'b0;
    end
  end

  // Terminal flags the bound in the selected counting direction, whether or not enabled.
  always_comb begin
    bus.Terminal = ((bus.Mode == MODE_UP) && (q >= MAX)) ||
                   ((bus.Mode == MODE_DOWN) && (q == '0));
  end

  assign bus.Q         = q;
  assign bus.SerialOut = serial_out;
  assign bus.Overflow  = overflow;
endmodule

// File: tb/tb_updown_shift_counter.sv
// Bench for updown_shift_counter: wrapping and saturating instances (SIZE=8, MAX=9) on shared stimulus.
module tb_updown_shift_counter;
  import updown_shift_counter_pkg::*;

  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] initial_v = '0;
  logic       enable = 1'b0;
  mode_e      mode = MODE_HOLD;
  logic       load = 1'b0;
  logic [7:0] d = '0;
  logic       serial_in = 1'b0;
  logic       clear_ovf = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference state, index 0 = wrapping instance, 1 = saturating instance.
  int mq[2];
  int mso[2];
  int movf[2];

  updown_shift_counter_if #(.SIZE(8)) if_w ();
  updown_shift_counter_if #(.SIZE(8)) if_s ();

  assign if_w.Initial = initial_v;  assign if_s.Initial = initial_v;
  assign if_w.Enable = enable;      assign if_s.Enable = enable;
  assign if_w.Mode = mode;          assign if_s.Mode = mode;
  assign if_w.Load = load;          assign if_s.Load = load;
  assign if_w.D = d;                assign if_s.D = d;
  assign if_w.SerialIn = serial_in; assign if_s.SerialIn = serial_in;
  assign if_w.ClearOvf = clear_ovf; assign if_s.ClearOvf = clear_ovf;

  updown_shift_counter #(.SIZE(8), .MAX(8'd9), .SATURATE(1'b0)) dut_w (
    .Clock(clk), .Reset(reset), .bus(if_w)
  );
  updown_shift_counter #(.SIZE(8), .MAX(8'd9), .SATURATE(1'b1)) dut_s (
    .Clock(clk), .Reset(reset), .bus(if_s)
  );

  always #5 clk = ~clk;

  function automatic int exp_term(int k);
    return ((mode == MODE_UP && mq[k] >= MAXV) || (mode == MODE_DOWN && mq[k] == 0)) ? 1 : 0;
  endfunction

  // One clock edge: advance the arithmetic reference, then return 1 time unit after the edge.
  task automatic cycle();
    int nq[2];
    int nso[2];
    int nov[2];
    for (int k = 0; k < 2; k++) begin
      nq[k] = mq[k]; nso[k] = mso[k]; nov[k] = movf[k];
      if (reset) begin
        nq[k] = initial_v; nso[k] = 0; nov[k] = 0;
      end else begin
        if (clear_ovf) nov[k] = 0;
        if (load) nq[k] = d;
        else if (enable) begin
          case (mode)
            MODE_UP:
              if (mq[k] >= MAXV) begin nq[k] = (k == 1) ? MAXV : 0; nov[k] = 1; end
              else nq[k] = mq[k] + 1;
            MODE_DOWN:
              if (mq[k] == 0) begin nq[k] = (k == 1) ? 0 : MAXV; nov[k] = 1; end
              else if (mq[k] > MAXV) nq[k] = MAXV;
              else nq[k] = mq[k] - 1;
            MODE_SHL: begin nq[k] = (mq[k] * 2 + serial_in) % 256; nso[k] = mq[k] / 128; end
            MODE_SHR: begin nq[k] = mq[k] / 2 + serial_in * 128;   nso[k] = mq[k] % 2; end
            MODE_ROL: begin nq[k] = (mq[k] * 2) % 256 + mq[k] / 128; nso[k] = mq[k] / 128; end
            MODE_ROR: begin nq[k] = mq[k] / 2 + (mq[k] % 2) * 128; nso[k] = mq[k] % 2; end
            default: ;
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      mq[k] = nq[k]; mso[k] = nso[k]; movf[k] = nov[k];
    end
  endtask

  task automatic idle();
    reset = 1'b0; enable = 1'b0; mode = MODE_HOLD; load = 1'b0;
    d = '0; serial_in = 1'b0; clear_ovf = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1; initial_v = 8'd3; load = 1'b1; d = 8'd5; enable = 1'b1; mode = MODE_UP;
    cycle();
    vectors++;
    if (if_w.Q !== 8'd3 || if_s.Q !== 8'd3) begin
      miscompares++; $display("FAIL reset_q: got %0d/%0d want 3", if_w.Q, if_s.Q);
    end
    vectors++;
    if (if_w.SerialOut !== 1'b0 || if_w.Overflow !== 1'b0 || if_s.Overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: so=%b ovf=%b/%b want 0", if_w.SerialOut, if_w.Overflow, if_s.Overflow);
    end
    idle();
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp_q[8];
    exp_q = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 8'd1};
    enable = 1'b1; mode = MODE_UP;
    for (int i = 0; i < 8; i++) begin
      cycle();
      vectors++;
      if (if_w.Q !== exp_q[i]) begin
        miscompares++; $display("FAIL up_q[%0d]: got %0d want %0d", i, if_w.Q, exp_q[i]);
      end
      vectors++;
      if (if_w.Terminal !== (exp_q[i] == 8'd9)) begin
        miscompares++; $display("FAIL up_term[%0d]: got %b at Q=%0d", i, if_w.Terminal, if_w.Q);
      end
    end
    vectors++;
    if (if_w.Overflow !== 1'b1) begin
      miscompares++; $display("FAIL up_ovf: got %b want 1", if_w.Overflow);
    end
    idle(); clear_ovf = 1'b1;
    cycle();
    vectors++;
    if (if_w.Overflow !== 1'b0 || if_s.Overflow !== 1'b0) begin
      miscompares++; $display("FAIL clear_ovf: got %b/%b want 0", if_w.Overflow, if_s.Overflow);
    end
    idle();
  endtask

  task automatic test_sat_down();
    load = 1'b1; d = 8'd1;
    cycle();
    idle(); enable = 1'b1; mode = MODE_DOWN;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if (if_s.Q !== 8'd0 || if_s.Terminal !== 1'b1) begin
        miscompares++; $display("FAIL sat_down[%0d]: q=%0d term=%b want 0/1", i, if_s.Q, if_s.Terminal);
      end
    end
    vectors++;
    if (if_s.Overflow !== 1'b1) begin
      miscompares++; $display("FAIL sat_down_ovf: got %b want 1", if_s.Overflow);
    end
    idle();
  endtask

  task automatic test_above_max();
    load = 1'b1; d = 8'hF0; clear_ovf = 1'b1;
    cycle();
    idle(); enable = 1'b1; mode = MODE_UP;
    cycle();
    vectors++;
    if (if_w.Q !== 8'd0 || if_w.Overflow !== 1'b1) begin
      miscompares++; $display("FAIL above_up_w: q=%0d ovf=%b want 0/1", if_w.Q, if_w.Overflow);
    end
    vectors++;
    if (if_s.Q !== 8'd9 || if_s.Overflow !== 1'b1) begin
      miscompares++; $display("FAIL above_up_s: q=%0d ovf=%b want 9/1", if_s.Q, if_s.Overflow);
    end
    idle(); load = 1'b1; d = 8'hF0; clear_ovf = 1'b1;
    cycle();
    idle(); enable = 1'b1; mode = MODE_DOWN;
    cycle();
    vectors++;
    if (if_w.Q !== 8'd9 || if_w.Overflow !== 1'b0) begin
      miscompares++; $display("FAIL above_down: q=%0d ovf=%b want 9/0", if_w.Q, if_w.Overflow);
    end
    idle();
  endtask

  task automatic test_shift();
    load = 1'b1; d = 8'b1000_0001;
    cycle();
    idle(); enable = 1'b1; mode = MODE_SHL; serial_in = 1'b0;
    cycle();
    vectors++;
    if (if_w.Q !== 8'h02 || if_w.SerialOut !== 1'b1) begin
      miscompares++; $display("FAIL shl: q=%h so=%b want 02/1", if_w.Q, if_w.SerialOut);
    end
    mode = MODE_ROR;
    cycle();
    vectors++;
    if (if_w.Q !== 8'h01 || if_w.SerialOut !== 1'b0) begin
      miscompares++; $display("FAIL ror: q=%h so=%b want 01/0", if_w.Q, if_w.SerialOut);
    end
    mode = MODE_SHR; serial_in = 1'b1;
    cycle();
    vectors++;
    if (if_w.Q !== 8'h80 || if_w.SerialOut !== 1'b1) begin
      miscompares++; $display("FAIL shr: q=%h so=%b want 80/1", if_w.Q, if_w.SerialOut);
    end
    idle();
  endtask

  task automatic test_priority();
    load = 1'b1; enable = 1'b1; mode = MODE_UP; d = 8'd5;
    cycle();
    vectors++;
    if (if_w.Q !== 8'd5) begin
      miscompares++; $display("FAIL load_over_enable: got %0d want 5", if_w.Q);
    end
    load = 1'b1; d = 8'd9; enable = 1'b0;
    cycle();
    load = 1'b0; enable = 1'b1; mode = MODE_UP;
    cycle();
    vectors++;
    if (if_w.Overflow !== 1'b1 || if_w.SerialOut !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_flags: ovf=%b so=%b want 1/1", if_w.Overflow, if_w.SerialOut);
    end
    reset = 1'b1; load = 1'b1; d = 8'd5; initial_v = 8'd3;
    cycle();
    vectors++;
    if (if_w.Q !== 8'd3 || if_w.Overflow !== 1'b0 || if_w.SerialOut !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_over_load: q=%0d ovf=%b so=%b want 3/0/0", if_w.Q, if_w.Overflow, if_w.SerialOut);
    end
    idle();
  endtask

  task automatic test_wrap_clear_hold();
    load = 1'b1; d = 8'd9;
    cycle();
    idle(); enable = 1'b1; mode = MODE_UP; clear_ovf = 1'b1;
    cycle();
    vectors++;
    if (if_w.Overflow !== 1'b1 || if_w.Q !== 8'd0) begin
      miscompares++; $display("FAIL set_beats_clear: ovf=%b q=%0d want 1/0", if_w.Overflow, if_w.Q);
    end
    clear_ovf = 1'b0; mode = MODE_RSVD;
    cycle();
    cycle();
    vectors++;
    if (if_w.Q !== 8'd0 || if_s.Q !== 8'd9) begin
      miscompares++; $display("FAIL reserved_hold: q=%0d/%0d want 0/9", if_w.Q, if_s.Q);
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      initial_v = 8'($urandom_range(0, 255));
      load      = ($urandom_range(0, 7) == 0);
      d         = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 10));
      enable    = ($urandom_range(0, 4) != 0);
      mode      = mode_e'($urandom_range(0, 7));
      serial_in = 1'($urandom_range(0, 1));
      clear_ovf = ($urandom_range(0, 7) == 0);
      #1;
      vectors++;
      if (if_w.Terminal !== 1'(exp_term(0)) || if_s.Terminal !== 1'(exp_term(1))) begin
        miscompares++;
        $display("FAIL rnd_term[%0d]: got %b/%b want %0d/%0d", n, if_w.Terminal, if_s.Terminal, exp_term(0), exp_term(1));
      end
      cycle();
      vectors++;
      if (if_w.Q !== 8'(mq[0]) || if_w.SerialOut !== 1'(mso[0]) || if_w.Overflow !== 1'(movf[0])) begin
        miscompares++;
        $display("FAIL rnd_wrap[%0d]: q=%0d so=%b ovf=%b want %0d/%0d/%0d", n,
                 if_w.Q, if_w.SerialOut, if_w.Overflow, mq[0], mso[0], movf[0]);
      end
      vectors++;
      if (if_s.Q !== 8'(mq[1]) || if_s.SerialOut !== 1'(mso[1]) || if_s.Overflow !== 1'(movf[1])) begin
        miscompares++;
        $display("FAIL rnd_sat[%0d]: q=%0d so=%b ovf=%b want %0d/%0d/%0d", n,
                 if_s.Q, if_s.SerialOut, if_s.Overflow, mq[1], mso[1], movf[1]);
      end
    end
    idle();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin mq[k] = 0; mso[k] = 0; movf[k] = 0; end
    #2;
    test_reset();
    test_up_wrap();
    test_sat_down();
    test_above_max();
    test_shift();
    test_priority();
    test_wrap_clear_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
